md_exec_unit: RTL and testbench

- Iterative RV64M multiply/divide unit in the EX stage.
- It produces `exe_is_waiting`, which holds the ID/EX pipeline register stable while an M-extension op is in progress.
- It accepts the EX-stage operands, runs a radix-2 shift-add or shift-subtract loop, and presents a 64-bit result for writeback when done.

---
 rtl/common_pkg.sv | 81 ++++++++
 rtl/md_sign_fix.sv | 36 +++
 rtl/md_exec_unit.sv | 162 ++++++++++++++++
 tb/tb_md_exec_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared types and op-decode helpers for the iterative RV64M multiply/divide unit.
package common;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned HALF  = XLEN / 2;
    localparam int unsigned ACC_W = 2 * XLEN;
    localparam int unsigned CNT_W = 7;

    typedef enum logic [3:0] {
        MD_MUL    = 4'd0,
        MD_MULH   = 4'd1,
        MD_MULHSU = 4'd2,
        MD_MULHU  = 4'd3,
        MD_DIV    = 4'd4,
        MD_DIVU   = 4'd5,
        MD_REM    = 4'd6,
        MD_REMU   = 4'd7,
        MD_MULW   = 4'd8,
        MD_DIVW   = 4'd9,
        MD_DIVUW  = 4'd10,
        MD_REMW   = 4'd11,
        MD_REMUW  = 4'd12
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    // Encodings 13..15 are not M-extension ops and are never accepted.
    function automatic logic is_md_op(md_op_t op);
        return 4'(op) <= 4'd12;
    endfunction

    function automatic logic is_div(md_op_t op);
        case (op)
            MD_DIV, MD_DIVU, MD_REM, MD_REMU,
            MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic is_rem(md_op_t op);
        case (op)
            MD_REM, MD_REMU, MD_REMW, MD_REMUW: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Low-half multiplies are sign-agnostic, so they run as unsigned.
    function automatic logic is_signed_a(md_op_t op);
        case (op)
            MD_MULH, MD_MULHSU, MD_DIV, MD_REM, MD_DIVW, MD_REMW: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_b(md_op_t op);
        case (op)
            MD_MULH, MD_DIV, MD_REM, MD_DIVW, MD_REMW: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    function automatic logic is_word(md_op_t op);
        case (op)
            MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic logic is_high(md_op_t op);
        case (op)
            MD_MULH, MD_MULHSU, MD_MULHU: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Final sign correction, half selection and W-op sign extension of the
// magnitude result held in the product / {remainder, quotient} accumulator.
module md_sign_fix
    import common::*;
(
    input  md_op_t             op,
    input  logic [ACC_W-1:0]   acc,
    input  logic               neg_a,
    input  logic               neg_b,
    output logic [XLEN-1:0]    result
);

    logic [ACC_W-1:0] prod_raw;
    logic [ACC_W-1:0] prod;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  sel;

    always_comb begin
        // A W multiply only runs HALF iterations, leaving its product mid-accumulator.
        prod_raw = is_word(op) ? ACC_W'(acc[XLEN+HALF-1:HALF]) : acc;
        prod     = (neg_a ^ neg_b) ? -prod_raw : prod_raw;

        quo = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem = neg_a ? -acc[ACC_W-1:XLEN] : acc[ACC_W-1:XLEN];

        if (is_div(op)) begin
            sel = is_rem(op) ? rem : quo;
        end else begin
            sel = is_high(op) ? prod[ACC_W-1:XLEN] : prod[XLEN-1:0];
        end

        result = is_word(op) ? {{HALF{sel[HALF-1]}}, sel[HALF-1:0]} : sel;
    end

endmodule

// File: rtl/md_exec_unit.sv
// Iterative radix-2 RV64M multiply/divide unit for the EX stage; stalls the
// ID/EX register via exe_is_waiting until the result is presented in DONE.
module md_exec_unit
    import common::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  md_op_t             op,
    input  logic [XLEN-1:0]    srca,
    input  logic [XLEN-1:0]    srcb,
    input  logic               hold,
    input  logic               flush,
    output logic               exe_is_waiting,
    output logic               result_valid,
    output logic [XLEN-1:0]    result
);

    md_state_t          state;
    md_op_t             op_q;
    logic [ACC_W-1:0]   acc;
    logic [XLEN-1:0]    mcand;
    logic               neg_a_q;
    logic               neg_b_q;
    logic [CNT_W-1:0]   cnt;
    logic [XLEN-1:0]    result_q;

    logic               word;
    logic               sa;
    logic               sb;
    logic               na;
    logic               nb;
    logic [XLEN-1:0]    a_ext;
    logic [XLEN-1:0]    b_ext;
    logic [XLEN-1:0]    mag_a;
    logic [XLEN-1:0]    mag_b;
    logic [XLEN-1:0]    min_val;
    logic [XLEN-1:0]    special_res;
    logic               div_zero;
    logic               div_ovf;
    logic               accept;
    logic [ACC_W-1:0]   acc_init;
    logic [XLEN:0]      mul_sum;
    logic [ACC_W-1:0]   mul_next;
    logic [XLEN:0]      div_diff;
    logic [ACC_W-1:0]   div_next;
    logic [XLEN-1:0]    fix_res;

    // Operand preparation and special-case detection for the accept cycle.
    always_comb begin
        word = is_word(op);
        sa   = is_signed_a(op);
        sb   = is_signed_b(op);

        a_ext = srca;
        b_ext = srcb;
        if (word) begin
            a_ext = sa ? {{HALF{srca[HALF-1]}}, srca[HALF-1:0]} : {HALF'(0), srca[HALF-1:0]};
            b_ext = sb ? {{HALF{srcb[HALF-1]}}, srcb[HALF-1:0]} : {HALF'(0), srcb[HALF-1:0]};
        end

        na    = sa & a_ext[XLEN-1];
        nb    = sb & b_ext[XLEN-1];
        mag_a = na ? -a_ext : a_ext;
        mag_b = nb ? -b_ext : b_ext;

        min_val  = word ? {{(HALF+1){1'b1}}, (HALF-1)'(0)} : {1'b1, (XLEN-1)'(0)};
        div_zero = is_div(op) & (b_ext == '0);
        div_ovf  = is_div(op) & sa & (a_ext == min_val) & (b_ext == '1);

        // Dividend is reported W-sign-extended, matching the FIX path.
        special_res = '0;
        if (div_zero) begin
            special_res = is_rem(op) ? {{HALF{srca[HALF-1]}}, srca[HALF-1:0]} : '1;
            if (!word && is_rem(op)) special_res = srca;
        end else if (div_ovf) begin
            special_res = is_rem(op) ? '0 : (word ? min_val : srca);
        end

        // W divides start with the dividend left-aligned so HALF steps consume it.
        acc_init = {XLEN'(0), (word & is_div(op)) ? {mag_a[HALF-1:0], HALF'(0)} : mag_a};

        accept = (state == MD_IDLE) & req_valid & ~flush & is_md_op(op);
    end

    // One shift-add or restoring shift-subtract step per BUSY cycle.
    always_comb begin
        mul_sum  = {1'b0, acc[ACC_W-1:XLEN]} + (acc[0] ? {1'b0, mcand} : (XLEN+1)'(0));
        mul_next = {mul_sum, acc[XLEN-1:1]};

        div_diff = acc[ACC_W-1:XLEN-1] - {1'b0, mcand};
        div_next = div_diff[XLEN] ? {acc[ACC_W-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    md_sign_fix u_sign_fix (
        .op     (op_q),
        .acc    (acc),
        .neg_a  (neg_a_q),
        .neg_b  (neg_b_q),
        .result (fix_res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= MD_IDLE;
            op_q     <= MD_MUL;
            acc      <= '0;
            mcand    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
        end else if (flush) begin
            state    <= MD_IDLE;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (accept) begin
                        op_q    <= op;
                        neg_a_q <= na;
                        neg_b_q <= nb;
                        mcand   <= mag_b;
                        acc     <= acc_init;
                        cnt     <= word ? CNT_W'(HALF) : CNT_W'(XLEN);
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            state    <= MD_DONE;
                        end else begin
                            state <= MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    acc <= is_div(op_q) ? div_next : mul_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= MD_FIX;
                end
                MD_FIX: begin
                    result_q <= fix_res;
                    state    <= MD_DONE;
                end
                MD_DONE: begin
                    // req_valid here still names the finished op, so never restart from DONE.
                    if (!hold) begin
                        result_q <= '0;
                        state    <= MD_IDLE;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign exe_is_waiting = reset & (accept | (state == MD_BUSY) | (state == MD_FIX));
    assign result_valid   = (state == MD_DONE);
    assign result         = result_q;

endmodule

// File: tb/tb_md_exec_unit.sv
// Directed, table-driven bench for md_exec_unit plus hand sequences for
// hold, flush, reset and back-to-back corner cases.
module tb_md_exec_unit;
    import common::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid;
    md_op_t             op;
    logic [XLEN-1:0]    srca;
    logic [XLEN-1:0]    srcb;
    logic               hold;
    logic               flush;
    logic               exe_is_waiting;
    logic               result_valid;
    logic [XLEN-1:0]    result;

    int total = 0;
    int bad   = 0;

    typedef struct {
        md_op_t       op;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [63:0]  exp;
        int           cyc;
        int           hold_n;
    } vec_t;

    vec_t vecs[19];

    md_exec_unit dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .op             (op),
        .srca           (srca),
        .srcb           (srcb),
        .hold           (hold),
        .flush          (flush),
        .exe_is_waiting (exe_is_waiting),
        .result_valid   (result_valid),
        .result         (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issue one op at a negedge, count waiting cycles, then check DONE and exit.
    task automatic run_vec(input vec_t v, input string nm);
        int n;
        @(negedge clk);
        op = v.op; srca = v.a; srcb = v.b; hold = 1'b0; req_valid = 1'b1;
        #1;
        n = 0;
        while (exe_is_waiting && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({nm, " wait"}, 64'(n), 64'(v.cyc));
        check({nm, " valid"}, 64'(result_valid), 64'd1);
        check({nm, " result"}, result, v.exp);
        if (v.hold_n > 0) begin
            hold = 1'b1;
            for (int i = 0; i < v.hold_n; i++) begin
                @(negedge clk);
                #1;
                check({nm, " hold valid"}, 64'(result_valid), 64'd1);
                check({nm, " hold result"}, result, v.exp);
                check({nm, " hold wait"}, 64'(exe_is_waiting), 64'd0);
            end
            hold = 1'b0;
        end
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        check({nm, " exit valid"}, 64'(result_valid), 64'd0);
        check({nm, " exit result"}, result, 64'd0);
    endtask

    initial begin
        int seen;
        int n;

        vecs[0]  = '{MD_MUL,    64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 66, 0};
        vecs[1]  = '{MD_MULHU,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0};
        vecs[2]  = '{MD_MULH,   '1, '1, 64'd0, 66, 0};
        vecs[3]  = '{MD_DIV,    64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0};
        vecs[4]  = '{MD_REM,    64'd100, 64'd0, 64'd100, 1, 0};
        vecs[5]  = '{MD_DIV,    64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0};
        vecs[6]  = '{MD_REM,    64'h8000_0000_0000_0000, '1, 64'd0, 1, 0};
        vecs[7]  = '{MD_REMW,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0};
        vecs[8]  = '{MD_DIVUW,  64'h1_0000_000A, 64'd3, 64'd3, 34, 0};
        vecs[9]  = '{MD_DIVU,   64'd1000, 64'd7, 64'd142, 66, 3};
        vecs[10] = '{MD_DIV,    -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 66, 0};
        vecs[11] = '{MD_REM,    -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0};
        vecs[12] = '{MD_MULHSU, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0};
        vecs[13] = '{MD_MULW,   64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0};
        vecs[14] = '{MD_DIVW,   -64'sd8, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0};
        vecs[15] = '{MD_REMUW,  64'hFFFF_FFFF, 64'd10, 64'd5, 34, 0};
        vecs[16] = '{MD_DIVW,   64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0};
        vecs[17] = '{MD_MUL,    64'h1234_5678_9ABC_DEF0, 64'h10, 64'h2345_6789_ABCD_EF00, 66, 0};
        vecs[18] = '{MD_REMU,   64'd1000, 64'd7, 64'd6, 66, 0};

        reset = 1'b0; req_valid = 1'b0; op = MD_MUL; srca = '0; srcb = '0;
        hold = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset wait", 64'(exe_is_waiting), 64'd0);
        check("reset valid", 64'(result_valid), 64'd0);
        check("reset result", result, 64'd0);
        reset = 1'b1;

        // Non-M encoding must neither stall nor start anything.
        @(negedge clk);
        op = md_op_t'(4'd13); req_valid = 1'b1;
        #1;
        check("non-m wait", 64'(exe_is_waiting), 64'd0);
        @(negedge clk);
        #1;
        check("non-m valid", 64'(result_valid), 64'd0);
        req_valid = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: DONE exit with req_valid already showing the next op.
        @(negedge clk);
        op = MD_DIVU; srca = 64'd1000; srcb = 64'd7; req_valid = 1'b1;
        #1;
        n = 0;
        while (exe_is_waiting && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("b2b first result", result, 64'd142);
        op = MD_REM; srca = 64'd100; srcb = 64'd0;
        @(negedge clk);
        #1;
        check("b2b idle valid", 64'(result_valid), 64'd0);
        check("b2b accept wait", 64'(exe_is_waiting), 64'd1);
        @(negedge clk);
        #1;
        check("b2b second valid", 64'(result_valid), 64'd1);
        check("b2b second result", result, 64'd100);
        req_valid = 1'b0;
        @(negedge clk);

        // Flush in BUSY cycle 10 of a DIV.
        op = MD_DIV; srca = 64'd1000; srcb = 64'd7; req_valid = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush busy wait", 64'(exe_is_waiting), 64'd1);
        @(negedge clk);
        #1;
        check("flush idle wait", 64'(exe_is_waiting), 64'd0);
        check("flush idle valid", 64'(result_valid), 64'd0);
        flush = 1'b0; req_valid = 1'b0;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        check("flush no valid", 64'(seen), 64'd0);

        // Reset in the middle of a MUL, then a fresh MUL.
        @(negedge clk);
        op = MD_MUL; srca = 64'd123; srcb = 64'd456; req_valid = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset wait", 64'(exe_is_waiting), 64'd0);
        check("midreset valid", 64'(result_valid), 64'd0);
        check("midreset result", result, 64'd0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_vec('{MD_MUL, 64'd5, 64'd6, 64'd30, 66, 0}, "post-reset mul");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
